// File: rtl/t06_cell_draw_queue.sv
// Cell draw queue: captures changed grid cells from the frame tracker into a
// small FIFO and issues each one as a pixel rectangle + RGB565 colour to the
// LCD fill engine over a req/ack handshake.
module t06_cell_draw_queue #(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CELL_PX      = 20,
  parameter logic [15:0] COLOR_EMPTY  = 16'h0000,
  parameter logic [15:0] COLOR_HEAD   = 16'h07E0,
  parameter logic [15:0] COLOR_BODY   = 16'h03E0,
  parameter logic [15:0] COLOR_APPLE  = 16'hF800,
  parameter logic [15:0] COLOR_BORDER = 16'hFFFF
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [3:0]  x,
  input  logic [3:0]  y,
  input  logic [2:0]  obj_code,
  input  logic        diff,
  output logic        scan_enable,
  output logic        draw_req,
  output logic [8:0]  draw_x0,
  output logic [7:0]  draw_y0,
  output logic [8:0]  draw_x1,
  output logic [7:0]  draw_y1,
  output logic [15:0] draw_color,
  input  logic        draw_ack,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [10:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic [8:0]  x0_q, x0_d, x1_q, x1_d;
  logic [7:0]  y0_q, y0_d, y1_q, y1_d;
  logic [15:0] color_q, color_d;

  logic        pop;
  logic        push_req;
  logic        push;
  logic        full;
  logic [10:0] head;
  logic [3:0]  head_x;
  logic [3:0]  head_y;
  logic [2:0]  head_code;

  function automatic logic [15:0] code_color(input logic [2:0] code);
    logic [15:0] c;
    case (code)
      3'd1:    c = COLOR_HEAD;
      3'd2:    c = COLOR_BODY;
      3'd3:    c = COLOR_APPLE;
      3'd4:    c = COLOR_BORDER;
      default: c = COLOR_EMPTY;
    endcase
    return c;
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: pop the head when idle and non-empty, wait for ack in REQ
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = REQ;
          end
        end
        REQ: begin
          if (draw_ack) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign head_x    = head[10:7];
  assign head_y    = head[6:3];
  assign head_code = head[2:0];

  assign push_req = in_valid && diff && (y <= 4'd11);
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign push     = push_req && !clear && (!full || pop);

  // FIFO pointer/count/overflow next-state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (push_req && full && !pop) overflow_d = 1'b1;
    end
  end

  // FIFO control registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage: {x, y, obj_code} per entry
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {x, y, obj_code};
  end

  // Rectangle and colour for the head entry, truncated to port widths
  always_comb begin
    x0_d    = 9'(head_x) * 9'(CELL_PX);
    y0_d    = 8'(head_y) * 8'(CELL_PX);
    x1_d    = x0_d + 9'(CELL_PX - 1);
    y1_d    = y0_d + 8'(CELL_PX - 1);
    color_d = code_color(head_code);
  end

  // Draw output registers: loaded on pop, otherwise held (clear keeps them)
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
    end else if (pop) begin
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      color_q <= color_d;
    end
  end

  assign draw_req    = (state_q == REQ);
  assign draw_x0     = x0_q;
  assign draw_y0     = y0_q;
  assign draw_x1     = x1_q;
  assign draw_y1     = y1_q;
  assign draw_color  = color_q;
  assign overflow    = overflow_q;
  assign scan_enable = (count_q < CNT_W'(FIFO_DEPTH - 1));
  assign busy        = (count_q != '0) || draw_req;

endmodule

// File: tb/tb_t06_cell_draw_queue.sv
// Directed testbench for t06_cell_draw_queue.
module tb_t06_cell_draw_queue;

  logic        clk;
  logic        nrst;
  logic        clear;
  logic        in_valid;
  logic [3:0]  x;
  logic [3:0]  y;
  logic [2:0]  obj_code;
  logic        diff;
  logic        scan_enable;
  logic        draw_req;
  logic [8:0]  draw_x0;
  logic [7:0]  draw_y0;
  logic [8:0]  draw_x1;
  logic [7:0]  draw_y1;
  logic [15:0] draw_color;
  logic        draw_ack;
  logic        busy;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  t06_cell_draw_queue #(
    .FIFO_DEPTH(8),
    .CELL_PX(20)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .clear(clear),
    .in_valid(in_valid),
    .x(x),
    .y(y),
    .obj_code(obj_code),
    .diff(diff),
    .scan_enable(scan_enable),
    .draw_req(draw_req),
    .draw_x0(draw_x0),
    .draw_y0(draw_y0),
    .draw_x1(draw_x1),
    .draw_y1(draw_y1),
    .draw_color(draw_color),
    .draw_ack(draw_ack),
    .busy(busy),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected colour table for obj_code values
  function automatic logic [15:0] exp_color(input int code);
    case (code)
      1:       return 16'h07E0;
      2:       return 16'h03E0;
      3:       return 16'hF800;
      4:       return 16'hFFFF;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cell(input logic v, input int cx, input int cy, input int code, input logic d);
    in_valid = v;
    x        = 4'(cx);
    y        = 4'(cy);
    obj_code = 3'(code);
    diff     = d;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; clear = 1'b0; draw_ack = 1'b0;
    set_cell(1'b0, 0, 0, 0, 1'b0);
    #12;
    total++;
    if ({draw_req, busy, overflow, scan_enable} !== 4'b0001) begin
      bad++;
      $display("FAIL reset_flags got req/busy/ovf/se=%b want 0001", {draw_req, busy, overflow, scan_enable});
    end
    total++;
    if ({draw_x0, draw_y0, draw_x1, draw_y1, draw_color} !== 50'd0) begin
      bad++;
      $display("FAIL reset_coords got %h want 0", {draw_x0, draw_y0, draw_x1, draw_y1, draw_color});
    end
    #5 nrst = 1'b1;
    step();
  endtask

  task automatic test_single();
    set_cell(1'b1, 3, 2, 2, 1'b1);
    step();
    in_valid = 1'b0;
    total++;
    if ({draw_req, busy} !== 2'b01) begin
      bad++;
      $display("FAIL single_latency1 got req/busy=%b want 01", {draw_req, busy});
    end
    step();
    total++;
    if (draw_req !== 1'b1) begin
      bad++;
      $display("FAIL single_req got %b want 1", draw_req);
    end
    total++;
    if ({draw_x0, draw_y0, draw_x1, draw_y1, draw_color} !== {9'd60, 8'd40, 9'd79, 8'd59, 16'h03E0}) begin
      bad++;
      $display("FAIL single_rect got x0=%0d y0=%0d x1=%0d y1=%0d c=%h want 60 40 79 59 03e0",
               draw_x0, draw_y0, draw_x1, draw_y1, draw_color);
    end
    draw_ack = 1'b1;
    step();
    draw_ack = 1'b0;
    total++;
    if ({draw_req, busy} !== 2'b00) begin
      bad++;
      $display("FAIL single_ack got req/busy=%b want 00", {draw_req, busy});
    end
  endtask

  task automatic test_bounds();
    set_cell(1'b1, 15, 11, 4, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    total++;
    if ({draw_req, draw_x0, draw_y0, draw_x1, draw_y1, draw_color} !==
        {1'b1, 9'd300, 8'd220, 9'd319, 8'd239, 16'hFFFF}) begin
      bad++;
      $display("FAIL corner_rect got req=%b x0=%0d y0=%0d x1=%0d y1=%0d c=%h want 1 300 220 319 239 ffff",
               draw_req, draw_x0, draw_y0, draw_x1, draw_y1, draw_color);
    end
    draw_ack = 1'b1;
    step();
    draw_ack = 1'b0;
    set_cell(1'b1, 5, 12, 1, 1'b1);
    step();
    total++;
    if ({busy, scan_enable} !== 2'b01) begin
      bad++;
      $display("FAIL y12_ignored got busy/se=%b want 01", {busy, scan_enable});
    end
    set_cell(1'b1, 5, 3, 1, 1'b0);
    step();
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL diff0_ignored got busy=%b want 0", busy);
    end
    step();
    total++;
    if (draw_req !== 1'b0) begin
      bad++;
      $display("FAIL ignored_no_req got req=%b want 0", draw_req);
    end
  endtask

  // Ten pushes on consecutive edges with ack held low: the first entry is
  // popped into REQ, so the FIFO reaches 7 after push 8, 8 after push 9, and
  // push 10 is dropped.
  task automatic test_fill();
    draw_ack = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      set_cell(1'b1, k, k - 1, (k - 1) % 5, 1'b1);
      step();
      total++;
      if (scan_enable !== (k < 8)) begin
        bad++;
        $display("FAIL fill_se k=%0d got %b want %b", k, scan_enable, (k < 8));
      end
      total++;
      if (overflow !== (k >= 10)) begin
        bad++;
        $display("FAIL fill_ovf k=%0d got %b want %b", k, overflow, (k >= 10));
      end
      if (k >= 2) begin
        total++;
        if ({draw_req, draw_x0, draw_y0} !== {1'b1, 9'd20, 8'd0}) begin
          bad++;
          $display("FAIL fill_hold k=%0d got req=%b x0=%0d y0=%0d want 1 20 0", k, draw_req, draw_x0, draw_y0);
        end
      end
    end
    in_valid = 1'b0;
    for (int j = 0; j < 9; j++) begin
      total++;
      if ({draw_req, draw_x0, draw_y0, draw_color} !==
          {1'b1, 9'((j + 1) * 20), 8'(j * 20), exp_color(j % 5)}) begin
        bad++;
        $display("FAIL fill_order j=%0d got req=%b x0=%0d y0=%0d c=%h want 1 %0d %0d %h",
                 j, draw_req, draw_x0, draw_y0, draw_color, (j + 1) * 20, j * 20, exp_color(j % 5));
      end
      draw_ack = 1'b1;
      step();
      draw_ack = 1'b0;
      total++;
      if (draw_req !== 1'b0) begin
        bad++;
        $display("FAIL fill_gap j=%0d got req=%b want 0", j, draw_req);
      end
      step();
    end
    total++;
    if ({draw_req, busy, overflow} !== 3'b001) begin
      bad++;
      $display("FAIL fill_drained got req/busy/ovf=%b want 001", {draw_req, busy, overflow});
    end
    do_clear();
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL fill_clear_ovf got %b want 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    draw_ack = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      if (e <= 4) set_cell(1'b1, 1 + e, 3, 1, 1'b1);
      else        in_valid = 1'b0;
      step();
      total++;
      if (draw_req !== (e % 2 == 0)) begin
        bad++;
        $display("FAIL b2b_req e=%0d got %b want %b", e, draw_req, (e % 2 == 0));
      end
      if (e % 2 == 0) begin
        total++;
        if ({draw_x0, draw_y0, draw_color} !== {9'((e / 2 + 1) * 20), 8'd60, 16'h07E0}) begin
          bad++;
          $display("FAIL b2b_entry e=%0d got x0=%0d y0=%0d c=%h want %0d 60 07e0",
                   e, draw_x0, draw_y0, draw_color, (e / 2 + 1) * 20);
        end
      end
    end
    draw_ack = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle got busy=%b want 0", busy);
    end
  endtask

  // Nine pushes leave 8 queued plus one in REQ; after its ack the FSM is idle
  // with a full FIFO, and a push on the following pop edge must be kept.
  task automatic test_full_pushpop();
    draw_ack = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      set_cell(1'b1, k, 0, 2, 1'b1);
      step();
    end
    in_valid = 1'b0;
    draw_ack = 1'b1;
    step();
    draw_ack = 1'b0;
    set_cell(1'b1, 15, 11, 3, 1'b1);
    step();
    in_valid = 1'b0;
    total++;
    if ({draw_req, overflow, scan_enable, draw_x0} !== {1'b1, 1'b0, 1'b0, 9'd40}) begin
      bad++;
      $display("FAIL full_pushpop got req=%b ovf=%b se=%b x0=%0d want 1 0 0 40",
               draw_req, overflow, scan_enable, draw_x0);
    end
    for (int j = 0; j < 9; j++) begin
      total++;
      if ({draw_req, draw_x0} !== {1'b1, ((j < 8) ? 9'((j + 2) * 20) : 9'd300)}) begin
        bad++;
        $display("FAIL full_drain j=%0d got req=%b x0=%0d want 1 %0d",
                 j, draw_req, draw_x0, (j < 8) ? (j + 2) * 20 : 300);
      end
      draw_ack = 1'b1;
      step();
      draw_ack = 1'b0;
      step();
    end
    total++;
    if ({draw_req, busy, overflow} !== 3'b000) begin
      bad++;
      $display("FAIL full_end got req/busy/ovf=%b want 000", {draw_req, busy, overflow});
    end
  endtask

  task automatic test_clear();
    draw_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_cell(1'b1, 7 + k, 5, 3, 1'b1);
      step();
    end
    in_valid = 1'b0;
    total++;
    if ({draw_req, busy} !== 2'b11) begin
      bad++;
      $display("FAIL clear_pre got req/busy=%b want 11", {draw_req, busy});
    end
    do_clear();
    total++;
    if ({draw_req, busy, overflow, scan_enable} !== 4'b0001) begin
      bad++;
      $display("FAIL clear_flags got req/busy/ovf/se=%b want 0001", {draw_req, busy, overflow, scan_enable});
    end
    total++;
    if ({draw_x0, draw_y0, draw_color} !== {9'd140, 8'd100, 16'hF800}) begin
      bad++;
      $display("FAIL clear_keep got x0=%0d y0=%0d c=%h want 140 100 f800", draw_x0, draw_y0, draw_color);
    end
    step();
    total++;
    if (draw_req !== 1'b0) begin
      bad++;
      $display("FAIL clear_stays got req=%b want 0", draw_req);
    end
  endtask

  task automatic test_reset_mid();
    set_cell(1'b1, 9, 9, 4, 1'b1);
    step();
    set_cell(1'b1, 2, 2, 1, 1'b1);
    step();
    in_valid = 1'b0;
    #2 nrst = 1'b0;
    #1;
    total++;
    if ({draw_req, busy, overflow, scan_enable} !== 4'b0001) begin
      bad++;
      $display("FAIL rst_mid_flags got req/busy/ovf/se=%b want 0001", {draw_req, busy, overflow, scan_enable});
    end
    total++;
    if ({draw_x0, draw_y0, draw_x1, draw_y1, draw_color} !== 50'd0) begin
      bad++;
      $display("FAIL rst_mid_coords got %h want 0", {draw_x0, draw_y0, draw_x1, draw_y1, draw_color});
    end
    #1 nrst = 1'b1;
    step();
    step();
    total++;
    if ({draw_req, busy} !== 2'b00) begin
      bad++;
      $display("FAIL rst_mid_after got req/busy=%b want 00", {draw_req, busy});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bounds();
    test_fill();
    test_back_to_back();
    test_full_pushpop();
    test_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
